cpu_alu: RTL and testbench

8-bit arithmetic/logic unit for the 6502-compatible NES CPU core. It takes two 8-bit operands, a carry input and an operation mode, and produces an 8-bit result plus carry, overflow, zero and sign flags. The controller feeds `alu_a` from the accumulator and `alu_b` from the data bus or the index registers. The flag outputs drive the processor status bits C, V, Z and N.

---
 rtl/cpu_alu_pkg.sv | 10 +
 rtl/cpu_alu_adder.sv | 10 +
 rtl/cpu_alu.sv | 51 +++++
 tb/tb_cpu_alu.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared CPU ALU operation codes and mode width.
package cpu_alu_pkg;
  localparam int MODE_W = 5;
  localparam logic [MODE_W-1:0] ALU_ADD = 5'd0;
  localparam logic [MODE_W-1:0] ALU_AND = 5'd1;
  localparam logic [MODE_W-1:0] ALU_OR  = 5'd2;
  localparam logic [MODE_W-1:0] ALU_EOR = 5'd3;
  localparam logic [MODE_W-1:0] ALU_SR  = 5'd4;
  localparam logic [MODE_W-1:0] ALU_SUB = 5'd5;
endpackage

// File: rtl/cpu_alu_adder.sv
// cpu_alu_adder: 8-bit ripple adder with carry in/out, shared by ADD and SUB.
module cpu_alu_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

// File: rtl/cpu_alu.sv
// cpu_alu: 6502-style 8-bit ALU with registered result and C/V/Z/N flags.
module cpu_alu
  import cpu_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        alu_a,
  input  logic [7:0]        alu_b,
  input  logic [MODE_W-1:0] mode,
  input  logic              carry_in,
  output logic [7:0]        alu_out,
  output logic              carry_out,
  output logic              overflow,
  output logic              zero,
  output logic              sign
);
  logic [7:0] b_in, sum, r;
  logic       cout, c, v;
  // Subtract as a + ~b + carry_in, so carry out doubles as "no borrow"
  assign b_in = (mode == ALU_SUB) ? ~alu_b : alu_b;
  cpu_alu_adder u_adder (
    .a(alu_a), .b(b_in), .cin(carry_in), .sum(sum), .cout(cout)
  );
  always_comb begin
    r = sum;
    c = cout;
    v = (alu_a[7] == b_in[7]) & (sum[7] != alu_a[7]);
    case (mode)
      ALU_AND: begin r = alu_a & alu_b; c = carry_in; v = 1'b0; end
      ALU_OR:  begin r = alu_a | alu_b; c = carry_in; v = 1'b0; end
      ALU_EOR: begin r = alu_a ^ alu_b; c = carry_in; v = 1'b0; end
      ALU_SR:  begin r = {carry_in, alu_a[7:1]}; c = alu_a[0]; v = 1'b0; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= 8'h00;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else begin
      alu_out   <= r;
      carry_out <= c;
      overflow  <= v;
      zero      <= (r == 8'h00);
      sign      <= r[7];
    end
  end
endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: scoreboard bench for cpu_alu with directed and random operations.
module tb_cpu_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_a = '0, alu_b = '0;
  logic [4:0] mode = '0;
  logic       carry_in = 1'b0;
  logic [7:0] alu_out;
  logic       carry_out, overflow, zero, sign;
  int         checks = 0, errors = 0;
  logic [11:0] exp_q[$];

  cpu_alu dut (
    .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .mode(mode),
    .carry_in(carry_in), .alu_out(alu_out), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on unsigned/signed operand values
  function automatic logic [11:0] model(input logic [4:0] m, input logic [7:0] a, b, input logic ci);
    int s, ss;
    logic [7:0] r;
    logic c, v;
    c = ci;
    v = 1'b0;
    if (m == 5'd1) r = a & b;
    else if (m == 5'd2) r = a | b;
    else if (m == 5'd3) r = a ^ b;
    else if (m == 5'd4) begin
      r = 8'(int'(ci) * 128 + int'(a) / 2);
      c = (int'(a) % 2) == 1;
    end else if (m == 5'd5) begin
      s  = int'(a) - int'(b) - (ci ? 0 : 1);
      ss = int'($signed(a)) - int'($signed(b)) - (ci ? 0 : 1);
      r = 8'(s);
      c = s >= 0;
      v = ss > 127 || ss < -128;
    end else begin
      s  = int'(a) + int'(b) + int'(ci);
      ss = int'($signed(a)) + int'($signed(b)) + int'(ci);
      r = 8'(s);
      c = s > 255;
      v = ss > 127 || ss < -128;
    end
    return {r, c, v, r == 8'h00, r[7]};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got r=%h c=%b v=%b z=%b n=%b expected r=%h c=%b v=%b z=%b n=%b",
               name, got[11:4], got[3], got[2], got[1], got[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [4:0] m, input logic [7:0] a, b, input logic ci, input logic [11:0] e);
    @(negedge clk);
    mode = m; alu_a = a; alu_b = b; carry_in = ci;
    exp_q.push_back(e);
  endtask

  // Monitor: each edge retires the oldest outstanding operation
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0)
      check("result", {alu_out, carry_out, overflow, zero, sign}, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [4:0] rm;
    logic       rc;
    #3 check("reset_init", {alu_out, carry_out, overflow, zero, sign}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    drive(5'd0, 8'h01, 8'h01, 1'b0, {8'h02, 4'b0000});
    drive(5'd0, 8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101});
    drive(5'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010});
    drive(5'd5, 8'h50, 8'hF0, 1'b1, {8'h60, 4'b0000});
    drive(5'd5, 8'h50, 8'hB0, 1'b1, {8'hA0, 4'b0101});
    drive(5'd5, 8'h05, 8'h05, 1'b1, {8'h00, 4'b1010});
    drive(5'd1, 8'hF0, 8'h3C, 1'b1, {8'h30, 4'b1000});
    drive(5'd2, 8'hF0, 8'h3C, 1'b1, {8'hFC, 4'b1001});
    drive(5'd3, 8'hF0, 8'h3C, 1'b1, {8'hCC, 4'b1001});
    drive(5'd4, 8'h81, 8'hA5, 1'b0, {8'h40, 4'b1000});
    drive(5'd4, 8'h01, 8'h5A, 1'b1, {8'h80, 4'b1001});
    drive(5'd4, 8'h01, 8'hFF, 1'b0, {8'h00, 4'b1010});
    drive(5'd7, 8'h02, 8'h03, 1'b1, {8'h06, 4'b0000});
    drive(5'd0, 8'h10, 8'h20, 1'b0, {8'h30, 4'b0000});
    // Reset mid-stream: outstanding op is discarded, outputs clear without an edge
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check("reset_async", {alu_out, carry_out, overflow, zero, sign}, 12'h000);
    @(posedge clk);
    #1 check("reset_hold", {alu_out, carry_out, overflow, zero, sign}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      drive(rm, ra, rb, rc, model(rm, ra, rb, rc));
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
